// File: rtl/uart_rx_fifo_if.sv
// Drain/status bundle between uart_rx_fifo (slave) and its consumer (master).
// UART_RX_PARITY_EN adds the sticky parity_error_p flag.
interface uart_rx_fifo_if #(
    parameter int CNT_W = 6
);
    logic             fifo_rx_rd_en_p;
    logic [7:0]       fifo_rx_dout_p;
    logic             fifo_rx_empty_p;
    logic             fifo_rx_full_p;
    logic [CNT_W-1:0] fifo_rx_data_count_p;
    logic             receive_done_p;
    logic             receive_done_ack_p;
    logic             framing_error_p;
    logic             overrun_p;
    logic             error_clr_p;
`ifdef UART_RX_PARITY_EN
    logic             parity_error_p;
`endif

    modport master (
        output fifo_rx_rd_en_p,
        output receive_done_ack_p,
        output error_clr_p,
        input  fifo_rx_dout_p,
        input  fifo_rx_empty_p,
        input  fifo_rx_full_p,
        input  fifo_rx_data_count_p,
        input  receive_done_p,
        input  framing_error_p,
`ifdef UART_RX_PARITY_EN
        input  parity_error_p,
`endif
        input  overrun_p
    );

    modport slave (
        input  fifo_rx_rd_en_p,
        input  receive_done_ack_p,
        input  error_clr_p,
        output fifo_rx_dout_p,
        output fifo_rx_empty_p,
        output fifo_rx_full_p,
        output fifo_rx_data_count_p,
        output receive_done_p,
        output framing_error_p,
`ifdef UART_RX_PARITY_EN
        output parity_error_p,
`endif
        output overrun_p
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, receive FIFO and idle-gap end-of-frame flag.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky parity_error_p flag.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 6,
    parameter int IDLE_BITS  = 10
) (
    input  logic               clk210_p,
    input  logic               reset_n_p,
    input  logic               baud_16_x_p,
    input  logic               rx_p,
    uart_rx_fifo_if.slave      rx_bus
);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int IW         = 12;
    localparam int IDLE_TICKS = IDLE_BITS * 16;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_STOP   = 3'd3,
        RX_PUSH   = 3'd4
`ifdef UART_RX_PARITY_EN
        , RX_PARITY = 3'd5
`endif
    } rx_state_e;

`ifdef UART_RX_PARITY_EN
    function automatic logic even_parity_bad(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction
`endif

    logic             sync1_r;
    logic             sync2_r;
    logic             rx_s;
    rx_state_e        state_r;
    logic [3:0]       os_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             hunt_r;
    logic             armed_r;
    logic [IW-1:0]    idle_cnt_r;
    logic             done_r;
    logic             framing_err_r;
    logic             overrun_r;
`ifdef UART_RX_PARITY_EN
    logic             parity_err_r;
    logic             par_bad_r;
`endif

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             empty_r;
    logic             full_r;
    logic [7:0]       dout_r;
    logic             pop_s;
    logic             push_s;

    // Two-flop synchronizer, preset high to match the idle line.
    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_p;
            sync2_r <= sync1_r;
        end
    end

    assign rx_s = sync2_r;

    // A pop in the push cycle frees the slot, so a full FIFO can still accept.
    assign pop_s  = rx_bus.fifo_rx_rd_en_p & ~empty_r;
    assign push_s = (state_r == RX_PUSH) & (~full_r | pop_s);

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Frame receiver FSM with sticky errors and end-of-frame timing.
    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            state_r       <= RX_IDLE;
            os_cnt_r      <= 4'd0;
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'd0;
            hunt_r        <= 1'b0;
            armed_r       <= 1'b0;
            idle_cnt_r    <= '0;
            done_r        <= 1'b0;
            framing_err_r <= 1'b0;
            overrun_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r  <= 1'b0;
            par_bad_r     <= 1'b0;
`endif
        end else begin
            // Clears come first so a same-cycle set below overrides them.
            if (rx_bus.error_clr_p) begin
                framing_err_r <= 1'b0;
                overrun_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_r  <= 1'b0;
`endif
            end
            if (done_r && rx_bus.receive_done_ack_p) begin
                done_r <= 1'b0;
            end
            case (state_r)
                RX_IDLE: begin
                    if (baud_16_x_p) begin
                        if (rx_s) begin
                            hunt_r <= 1'b1;
                            if (armed_r) begin
                                if (idle_cnt_r == IW'(IDLE_TICKS - 1)) begin
                                    done_r     <= 1'b1;
                                    armed_r    <= 1'b0;
                                    idle_cnt_r <= '0;
                                end else begin
                                    idle_cnt_r <= idle_cnt_r + IW'(1);
                                end
                            end
                        end else if (hunt_r) begin
                            state_r    <= RX_START;
                            os_cnt_r   <= 4'd0;
                            idle_cnt_r <= '0;
                        end
                    end
                end
                RX_START: begin
                    if (baud_16_x_p) begin
                        if (os_cnt_r == 4'd7) begin
                            os_cnt_r  <= 4'd0;
                            bit_cnt_r <= 3'd0;
                            state_r   <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            os_cnt_r <= os_cnt_r + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (baud_16_x_p) begin
                        if (os_cnt_r == 4'd15) begin
                            os_cnt_r           <= 4'd0;
                            shift_r[bit_cnt_r] <= rx_s;
                            if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_r <= RX_PARITY;
`else
                                state_r <= RX_STOP;
`endif
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end else begin
                            os_cnt_r <= os_cnt_r + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (baud_16_x_p) begin
                        if (os_cnt_r == 4'd15) begin
                            os_cnt_r  <= 4'd0;
                            par_bad_r <= even_parity_bad(shift_r, rx_s);
                            state_r   <= RX_STOP;
                        end else begin
                            os_cnt_r <= os_cnt_r + 4'd1;
                        end
                    end
                end
`endif
                RX_STOP: begin
                    if (baud_16_x_p) begin
                        if (os_cnt_r == 4'd15) begin
                            os_cnt_r <= 4'd0;
                            if (!rx_s) begin
                                // Wait for the line to go high before hunting again.
                                framing_err_r <= 1'b1;
                                hunt_r        <= 1'b0;
                                state_r       <= RX_IDLE;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad_r) begin
                                parity_err_r <= 1'b1;
                                state_r      <= RX_IDLE;
`endif
                            end else begin
                                state_r <= RX_PUSH;
                            end
                        end else begin
                            os_cnt_r <= os_cnt_r + 4'd1;
                        end
                    end
                end
                RX_PUSH: begin
                    if (full_r && !pop_s) begin
                        overrun_r <= 1'b1;
                    end else begin
                        armed_r    <= 1'b1;
                        idle_cnt_r <= '0;
                    end
                    state_r <= RX_IDLE;
                end
                default: begin
                    state_r <= RX_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, flags and registered read port.
    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            dout_r   <= 8'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                dout_r   <= mem_r[rd_ptr_r];
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == CNT_W'(0));
            full_r  <= (count_nxt_s == CNT_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents are only observable after a write.
    always_ff @(posedge clk210_p) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    assign rx_bus.fifo_rx_dout_p       = dout_r;
    assign rx_bus.fifo_rx_empty_p      = empty_r;
    assign rx_bus.fifo_rx_full_p       = full_r;
    assign rx_bus.fifo_rx_data_count_p = count_r;
    assign rx_bus.receive_done_p       = done_r;
    assign rx_bus.framing_error_p      = framing_err_r;
    assign rx_bus.overrun_p            = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.parity_error_p       = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo: 16x tick every 4 clk, 64 clk per bit.
module tb_uart_rx_fifo;
    localparam int DEPTH = 32;

    logic clk210_p;
    logic reset_n_p;
    logic baud_16_x_p;
    logic rx_p;
    int   checks;
    int   errors;
    int   tick_div;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    bit   found;

    uart_rx_fifo_if #(.CNT_W(6)) rx_bus ();

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .CNT_W(6), .IDLE_BITS(10)) dut (
        .clk210_p    (clk210_p),
        .reset_n_p   (reset_n_p),
        .baud_16_x_p (baud_16_x_p),
        .rx_p        (rx_p),
        .rx_bus      (rx_bus)
    );

    initial begin
        clk210_p = 1'b0;
        forever #5 clk210_p = ~clk210_p;
    end

    initial begin
        baud_16_x_p = 1'b0;
        tick_div    = 0;
        forever begin
            @(negedge clk210_p);
            tick_div    = (tick_div + 1) % 4;
            baud_16_x_p = (tick_div == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk210_p);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_p = 1'b0;
        clks(64);
        for (int i = 0; i < 8; i++) begin
            rx_p = b[i];
            clks(64);
        end
`ifdef UART_RX_PARITY_EN
        rx_p = ^b;
        clks(64);
`endif
        rx_p = stop_bit;
        clks(64);
        rx_p = 1'b1;
    endtask

    task automatic sb_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
    endtask

    task automatic read_check(input string tag);
        rx_bus.fifo_rx_rd_en_p = 1'b1;
        clks(1);
        rx_bus.fifo_rx_rd_en_p = 1'b0;
        exp_b = exp_q.pop_front();
        check(tag, {24'd0, rx_bus.fifo_rx_dout_p}, {24'd0, exp_b});
    endtask

    task automatic pulse_ack();
        rx_bus.receive_done_ack_p = 1'b1;
        clks(1);
        rx_bus.receive_done_ack_p = 1'b0;
    endtask

    task automatic pulse_clr();
        rx_bus.error_clr_p = 1'b1;
        clks(1);
        rx_bus.error_clr_p = 1'b0;
    endtask

    // Bounded wait for the one-clk push state; timing probe only.
    task automatic wait_push(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk210_p);
            if (dut.state_r == 3'd4) seen = 1'b1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rx_p = 1'b1;
        reset_n_p = 1'b0;
        rx_bus.fifo_rx_rd_en_p    = 1'b0;
        rx_bus.receive_done_ack_p = 1'b0;
        rx_bus.error_clr_p        = 1'b0;
        clks(5);
        reset_n_p = 1'b1;
        clks(3);

        check("rst_dout",  {24'd0, rx_bus.fifo_rx_dout_p}, 32'd0);
        check("rst_empty", {31'd0, rx_bus.fifo_rx_empty_p}, 32'd1);
        check("rst_full",  {31'd0, rx_bus.fifo_rx_full_p}, 32'd0);
        check("rst_count", {26'd0, rx_bus.fifo_rx_data_count_p}, 32'd0);
        check("rst_done",  {31'd0, rx_bus.receive_done_p}, 32'd0);
        check("rst_fe",    {31'd0, rx_bus.framing_error_p}, 32'd0);
        check("rst_ov",    {31'd0, rx_bus.overrun_p}, 32'd0);

        // Single byte in and out.
        send_byte(8'hA5, 1'b1);
        sb_push(8'hA5);
        clks(2);
        check("a5_count", {26'd0, rx_bus.fifo_rx_data_count_p}, 32'(exp_q.size()));
        check("a5_empty", {31'd0, rx_bus.fifo_rx_empty_p}, 32'd0);
        read_check("a5_data");
        check("a5_empty_after", {31'd0, rx_bus.fifo_rx_empty_p}, 32'd1);
        check("a5_count_after", {26'd0, rx_bus.fifo_rx_data_count_p}, 32'd0);
        rx_bus.fifo_rx_rd_en_p = 1'b1;
        clks(1);
        rx_bus.fifo_rx_rd_en_p = 1'b0;
        check("empty_read_hold", {24'd0, rx_bus.fifo_rx_dout_p}, 32'hA5);

        // Short low glitch: no byte, no flags.
        rx_p = 1'b0;
        clks(20);
        rx_p = 1'b1;
        clks(200);
        check("glitch_count", {26'd0, rx_bus.fifo_rx_data_count_p}, 32'd0);
        check("glitch_fe",    {31'd0, rx_bus.framing_error_p}, 32'd0);
        check("glitch_ov",    {31'd0, rx_bus.overrun_p}, 32'd0);

        // Framing error and clear.
        send_byte(8'h3C, 1'b0);
        clks(2);
        check("fe_set",   {31'd0, rx_bus.framing_error_p}, 32'd1);
        check("fe_count", {26'd0, rx_bus.fifo_rx_data_count_p}, 32'd0);
        pulse_clr();
        check("fe_clr",   {31'd0, rx_bus.framing_error_p}, 32'd0);

        // Let any pending end-of-frame fire, then acknowledge it.
        clks(800);
        pulse_ack();
        check("done_pre_clear", {31'd0, rx_bus.receive_done_p}, 32'd0);

        // End-of-frame exactly 160 ticks after the last stop sample.
        send_byte(8'h11, 1'b1);
        sb_push(8'h11);
        fork
            send_byte(8'h22, 1'b1);
            begin
                wait_push(found);
                check("eof_push_seen", {31'd0, found}, 32'd1);
                clks(639);
                check("eof_early", {31'd0, rx_bus.receive_done_p}, 32'd0);
                clks(1);
                check("eof_set", {31'd0, rx_bus.receive_done_p}, 32'd1);
            end
        join
        sb_push(8'h22);
        clks(20);
        check("eof_held", {31'd0, rx_bus.receive_done_p}, 32'd1);
        pulse_ack();
        check("eof_ack", {31'd0, rx_bus.receive_done_p}, 32'd0);
        clks(800);
        check("eof_no_rearm", {31'd0, rx_bus.receive_done_p}, 32'd0);
        read_check("eof_rd0");
        read_check("eof_rd1");

        // Overfill: 33 bytes into 32 slots.
        for (int i = 0; i < 33; i++) begin
            send_byte(8'(i), 1'b1);
            sb_push(8'(i));
        end
        clks(2);
        check("ovf_full",  {31'd0, rx_bus.fifo_rx_full_p}, 32'd1);
        check("ovf_count", {26'd0, rx_bus.fifo_rx_data_count_p}, 32'd32);
        check("ovf_flag",  {31'd0, rx_bus.overrun_p}, 32'd1);
        for (int i = 0; i < DEPTH; i++) read_check("ovf_rd");
        check("ovf_drained", {31'd0, rx_bus.fifo_rx_empty_p}, 32'd1);
        pulse_clr();
        check("ov_clr", {31'd0, rx_bus.overrun_p}, 32'd0);

        // Push and pop on the same clk while full.
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'(8'h40 + i), 1'b1);
            sb_push(8'(8'h40 + i));
        end
        fork
            send_byte(8'h99, 1'b1);
            begin
                wait_push(found);
                check("pp_push_seen", {31'd0, found}, 32'd1);
                rx_bus.fifo_rx_rd_en_p = 1'b1;
                clks(1);
                rx_bus.fifo_rx_rd_en_p = 1'b0;
                exp_b = exp_q.pop_front();
                check("pp_oldest", {24'd0, rx_bus.fifo_rx_dout_p}, {24'd0, exp_b});
            end
        join
        sb_push(8'h99);
        clks(2);
        check("pp_count", {26'd0, rx_bus.fifo_rx_data_count_p}, 32'd32);
        check("pp_full",  {31'd0, rx_bus.fifo_rx_full_p}, 32'd1);
        check("pp_no_ov", {31'd0, rx_bus.overrun_p}, 32'd0);
        for (int i = 0; i < DEPTH; i++) read_check("pp_rd");
        check("pp_empty", {31'd0, rx_bus.fifo_rx_empty_p}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver, 8N1, LSB first; line sampled with a 16x oversample tick from the shared baud generator.
- Validated bytes are pushed into an internal FIFO; the top-level module drains the FIFO when it chooses.
- Flags end-of-frame after a configurable line-idle gap, using a done/ack handshake that mirrors the transmit side.
- Sits alongside the transmitter on the ground/payload serial link.

Parameters:
- FIFO_DEPTH, 32, receive FIFO depth in bytes; power of 2, minimum 4.
- CNT_W, 6, width of fifo_rx_data_count_p; equals log2(FIFO_DEPTH)+1.
- IDLE_BITS, 10, idle-line bit-times after the last byte before end-of-frame is flagged; range 1..255.

Ports:
- clk210_p, in, 1, system clock.
- reset_n_p, in, 1, asynchronous active-low reset.
- baud_16_x_p, in, 1, one-clk-wide strobe at 16x baud rate.
- rx_p, in, 1, asynchronous serial input; idles high.
- fifo_rx_rd_en_p, in, 1, pops one byte.
- fifo_rx_dout_p, out, 8, popped byte.
- fifo_rx_empty_p, out, 1, FIFO empty.
- fifo_rx_full_p, out, 1, FIFO full.
- fifo_rx_data_count_p, out, CNT_W, bytes held in the FIFO.
- receive_done_p, out, 1, end-of-frame flag.
- receive_done_ack_p, in, 1, acknowledges receive_done_p.
- framing_error_p, out, 1, sticky: a stop bit was sampled low.
- overrun_p, out, 1, sticky: a byte was dropped because the FIFO was full.
- error_clr_p, in, 1, clears the sticky error flags.

Behaviour:
- Reset (async assert, sync release):
  - State machine goes to RX_IDLE.
  - fifo_rx_dout_p=0, fifo_rx_empty_p=1, fifo_rx_full_p=0, count=0.
  - receive_done_p=0, framing_error_p=0, overrun_p=0.
  - Synchronizer flops preset to 1.
  - Reset mid-byte discards the partial byte and all FIFO contents.
- rx_p passes through a 2-FF synchronizer; all decisions use the synchronized value.
- All timing is counted in baud_16_x_p ticks with a 4-bit oversample counter; no state advances without a tick except RX_PUSH.
- RX_IDLE:
  - On a synchronized falling edge, clear the counter and go to RX_START.
- RX_START:
  - On the 8th tick (mid start bit), sample the line.
  - Line 0: clear counter and bit count, go to RX_DATA.
  - Line 1: treat as a glitch and return to RX_IDLE with no flag.
- RX_DATA:
  - Every 16th tick, sample into the shift register at bit position bit_count (LSB first).
  - After bit 7, go to RX_STOP.
- RX_STOP:
  - On the 16th tick, sample the line.
  - Line 1: go to RX_PUSH.
  - Line 0: set framing_error_p, discard the byte, go to RX_IDLE.
  - A framing error does not hunt for a new start bit until the line has returned high.
- RX_PUSH (one clk):
  - If not full, write the byte; otherwise set overrun_p and drop the byte.
  - Go to RX_IDLE.
- FIFO:
  - Read is registered: fifo_rx_dout_p updates on the clk after rd_en is sampled high with empty=0.
  - fifo_rx_rd_en_p while empty is ignored; dout holds its value.
  - Simultaneous push and pop: count unchanged; works when full (pop frees the slot) and when empty (no pop).
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Empty/full/count update on the clk after the operation.
- End of frame:
  - An armed flag sets on every successful push.
  - While armed and in RX_IDLE with the line high, count ticks; a start edge clears the count.
  - When the count reaches IDLE_BITS*16, set receive_done_p and clear the armed flag.
  - receive_done_p holds until receive_done_ack_p is sampled high, then clears on the next clk.
  - Ack while done=0 is ignored.
  - If done and a new arm-and-timeout occur together, done stays set.
- error_clr_p:
  - Clears both sticky flags on the next clk.
  - If a new error occurs in the same cycle, set wins.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; adds RX_PARITY state between RX_DATA and RX_STOP, sampling the 9th bit.
  - Adds output parity_error_p (1 bit, sticky, cleared by error_clr_p).
  - On even-parity mismatch, set parity_error_p and discard the byte even if the stop bit is valid.
- Undefined:
  - 8N1 only; no RX_PARITY state and no parity_error_p port.

Test Plan:
- Send 0xA5 at 16x tick every 4 clk -> after stop, count=1, empty=0; rd_en -> dout=0xA5 next clk, empty=1.
- Low pulse on rx_p of 5 ticks -> returns to RX_IDLE; count=0, no error flags set.
- Send 0x3C with stop bit forced 0 -> framing_error_p=1, count=0; error_clr_p -> flag 0 next clk.
- Send 33 bytes 0x00..0x20 with no reads (depth 32) -> full=1, count=32, overrun_p=1; 32 reads return 0x00..0x1F in order.
- Send 0x11, 0x22, then line idle for 10 bit-times -> receive_done_p=1 at tick 160 after the stop sample; held until ack, clears the next clk; no re-assert without a new byte.
- Push on the same clk as rd_en with count=32 -> count stays 32, oldest byte out, new byte retained, no overrun.
